// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Brief    : UART-driven program loader and run controller for the BIP-I CPU.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int IBITS = 16,
  parameter int ADDR  = 11
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_done,
  input  logic             i_tx_done,
  input  logic             i_halt,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_start,
  output logic             o_pm_wr_en,
  output logic [ADDR-1:0]  o_pm_addr,
  output logic [IBITS-1:0] o_pm_data,
  output logic             o_cpu_rst_n,
  output logic             o_cpu_en
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CNT_HI  = 4'd1,
    S_CNT_LO  = 4'd2,
    S_INST_HI = 4'd3,
    S_INST_LO = 4'd4,
    S_WRITE   = 4'd5,
    S_SEND    = 4'd6,
    S_WAIT_TX = 4'd7,
    S_RUN     = 4'd8
  } state_t;

  localparam logic [7:0]  c_cmd_load = 8'h4C;
  localparam logic [7:0]  c_cmd_run  = 8'h52;
  localparam logic [7:0]  c_ack      = 8'h06;
  localparam logic [7:0]  c_nak      = 8'h15;
  localparam logic [7:0]  c_halted   = 8'h48;
  localparam logic [16:0] c_cap      = 17'(1) << ADDR;

  state_t           r_state, w_state;
  logic [7:0]       r_hi, w_hi;
  logic [ADDR:0]    r_count, w_count;
  logic [ADDR:0]    r_wcnt, w_wcnt;
  logic [ADDR-1:0]  r_addr, w_addr;
  logic [IBITS-1:0] r_pm_data, w_pm_data;
  logic             r_pm_wr_en, w_pm_wr_en;
  logic [7:0]       r_tx_data, w_tx_data;
  logic             r_tx_start, w_tx_start;
  logic             r_cpu_rst_n, w_cpu_rst_n;
  logic             r_cpu_en, w_cpu_en;

  logic [15:0]      w_word;
  logic [ADDR:0]    w_wcnt_inc;

  assign w_word     = {r_hi, i_rx_data};
  assign w_wcnt_inc = r_wcnt + (ADDR+1)'(1);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_hi        <= '0;
      r_count     <= '0;
      r_wcnt      <= '0;
      r_addr      <= '0;
      r_pm_data   <= '0;
      r_pm_wr_en  <= 1'b0;
      r_tx_data   <= '0;
      r_tx_start  <= 1'b0;
      r_cpu_rst_n <= 1'b0;
      r_cpu_en    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_hi        <= w_hi;
      r_count     <= w_count;
      r_wcnt      <= w_wcnt;
      r_addr      <= w_addr;
      r_pm_data   <= w_pm_data;
      r_pm_wr_en  <= w_pm_wr_en;
      r_tx_data   <= w_tx_data;
      r_tx_start  <= w_tx_start;
      r_cpu_rst_n <= w_cpu_rst_n;
      r_cpu_en    <= w_cpu_en;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_hi        = r_hi;
    w_count     = r_count;
    w_wcnt      = r_wcnt;
    w_addr      = r_addr;
    w_pm_data   = r_pm_data;
    w_pm_wr_en  = 1'b0;
    w_tx_data   = r_tx_data;
    w_tx_start  = 1'b0;
    w_cpu_rst_n = r_cpu_rst_n;
    w_cpu_en    = r_cpu_en;

    case (r_state)
      S_IDLE: begin
        // A new command re-resets the CPU; a halted CPU is held until then.
        if (i_rx_done && (i_rx_data == c_cmd_load)) begin
          w_cpu_rst_n = 1'b0;
          w_cpu_en    = 1'b0;
          w_state     = S_CNT_HI;
        end else if (i_rx_done && (i_rx_data == c_cmd_run)) begin
          w_cpu_rst_n = 1'b0;
          w_cpu_en    = 1'b0;
          w_state     = S_RUN;
        end
      end
      S_CNT_HI: begin
        if (i_rx_done) begin
          w_hi    = i_rx_data;
          w_state = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (i_rx_done) begin
          if (w_word == 16'd0) begin
            w_tx_data = c_ack;
            w_state   = S_SEND;
          end else if ({1'b0, w_word} > c_cap) begin
            w_tx_data = c_nak;
            w_state   = S_SEND;
          end else begin
            w_count = w_word[ADDR:0];
            w_wcnt  = '0;
            w_addr  = '0;
            w_state = S_INST_HI;
          end
        end
      end
      S_INST_HI: begin
        if (i_rx_done) begin
          w_hi    = i_rx_data;
          w_state = S_INST_LO;
        end
      end
      S_INST_LO: begin
        if (i_rx_done) begin
          w_pm_data  = IBITS'(w_word);
          w_pm_wr_en = 1'b1;
          w_state    = S_WRITE;
        end
      end
      S_WRITE: begin
        // Address may wrap to 0 after a full-memory load; no write follows it.
        w_addr = r_addr + ADDR'(1);
        w_wcnt = w_wcnt_inc;
        if (w_wcnt_inc == r_count) begin
          w_tx_data = c_ack;
          w_state   = S_SEND;
        end else begin
          w_state = S_INST_HI;
        end
      end
      S_SEND: begin
        w_tx_start = 1'b1;
        w_state    = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (i_tx_done) begin
          w_state = S_IDLE;
        end
      end
      S_RUN: begin
        // Halt is only meaningful once the CPU is out of reset and clocked.
        if (r_cpu_en && i_halt) begin
          w_cpu_en  = 1'b0;
          w_tx_data = c_halted;
          w_state   = S_SEND;
        end else begin
          w_cpu_rst_n = 1'b1;
          w_cpu_en    = 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign o_tx_data   = r_tx_data;
  assign o_tx_start  = r_tx_start;
  assign o_pm_wr_en  = r_pm_wr_en;
  assign o_pm_addr   = r_addr;
  assign o_pm_data   = r_pm_data;
  assign o_cpu_rst_n = r_cpu_rst_n;
  assign o_cpu_en    = r_cpu_en;

endmodule
`default_nettype wire
